// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one word request at a time to instruction memory
// and buffers {pc, instr} pairs in a show-ahead queue for decode.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] pcIn,
    input  logic        flush,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        pcAdvance,
    output logic        instrValid,
    output logic [31:0] instrOut,
    output logic [31:0] instrPc,
    input  logic        idReady
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]         out_pc_q, out_pc_d;
    entry_t [DEPTH-1:0]  mem_q, mem_d;
    logic                pop, resp_acc;
    logic [CW:0]         occ_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instrValid = (count_q != '0);
    assign pop        = instrValid & idReady & ~flush;
    assign resp_acc   = imemRespValid & (state_q == WAIT) & ~flush;
    // Occupancy after this cycle's push/pop; a request is only issued if its response will fit.
    assign occ_next   = {1'b0, count_q} + {{CW{1'b0}}, resp_acc} - {{CW{1'b0}}, pop};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            out_pc_q <= '0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            out_pc_q <= out_pc_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pcAdvance) state_d = WAIT;
            WAIT: begin
                if (imemRespValid)  state_d = pcAdvance ? WAIT : IDLE;
                else if (flush)     state_d = DROP;
            end
            DROP: if (imemRespValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Held low during reset so an abandoned fetch is not re-issued before release.
    always_comb begin
        imemReqValid = 1'b0;
        if (rstN && !flush && (occ_next < (CW+1)'(DEPTH)))
            imemReqValid = (state_q == IDLE) | ((state_q == WAIT) & imemRespValid);
    end

    assign imemReqAddr = {pcIn[31:2], 2'b00};
    assign pcAdvance   = imemReqValid & imemReqReady;
    assign instrOut    = instrValid ? mem_q[rd_ptr_q].instr : '0;
    assign instrPc     = instrValid ? mem_q[rd_ptr_q].pc    : '0;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        out_pc_d = pcAdvance ? pcIn : out_pc_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (resp_acc) begin
                mem_d[wr_ptr_q] = '{pc: out_pc_q, instr: imemRespData};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = occ_next[CW-1:0];
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queue-level reference model checked every cycle,
// with a bench-side PC register and variable-latency instruction memory.
module tb_ifetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] pcIn = '0;
    logic        flush = 1'b0;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady = 1'b0;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = '0;
    logic        pcAdvance;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        idReady = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN), .pcIn(pcIn), .flush(flush),
        .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData), .pcAdvance(pcAdvance),
        .instrValid(instrValid), .instrOut(instrOut), .instrPc(instrPc), .idReady(idReady)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int          n_chk = 0;
    int          n_fail = 0;
    ent_t        mq[$];
    bit          m_busy = 0, m_drop = 0;
    logic [31:0] m_pc = '0;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    int          lat = 1;
    logic [31:0] mem_addr = '0;
    logic        s_req, s_adv, s_valid;
    logic [31:0] s_addr, s_out, s_pc;
    logic [31:0] delivered[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model at negedge, then advance everything.
    task automatic step(input bit fl, input logic [31:0] tgt, input bit idr, input bit rdy);
        int occ;
        bit e_valid, pop, racc, e_req;
        logic [31:0] e_out, e_pc;
        flush = fl;
        idReady = idr;
        imemReqReady = rdy;
        imemRespValid = mem_pend && (mem_cnt == 1);
        imemRespData = imemRespValid ? mem_word(mem_addr) : 32'hDEADBEEF;
        @(negedge clk);
        s_req = imemReqValid; s_adv = pcAdvance; s_addr = imemReqAddr;
        s_valid = instrValid; s_out = instrOut; s_pc = instrPc;

        occ = mq.size();
        e_valid = (occ > 0);
        e_out = '0;
        e_pc = '0;
        if (e_valid) begin
            e_out = mq[0].data;
            e_pc = mq[0].pc;
        end
        pop = e_valid && idr && !fl;
        racc = imemRespValid && m_busy && !m_drop && !fl;
        e_req = !fl && (!m_busy || (!m_drop && imemRespValid)) && ((occ - int'(pop) + int'(racc)) < DEPTH);
        chk("instrValid", {31'b0, s_valid}, {31'b0, e_valid});
        chk("instrOut", s_out, e_out);
        chk("instrPc", s_pc, e_pc);
        chk("imemReqValid", {31'b0, s_req}, {31'b0, e_req});
        chk("pcAdvance", {31'b0, s_adv}, {31'b0, e_req && rdy});
        if (e_req) chk("imemReqAddr", s_addr, {pcIn[31:2], 2'b00});
        if (s_valid && idr && !fl) delivered.push_back(s_pc);

        @(posedge clk);
        #1;
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (racc) mq.push_back('{pc: m_pc, data: imemRespData});
        end
        if (m_busy && imemRespValid) m_busy = 0;
        else if (m_busy && fl) m_drop = 1;
        if (e_req && rdy) begin
            m_busy = 1;
            m_drop = 0;
            m_pc = pcIn;
        end
        if (mem_pend && imemRespValid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (s_adv) begin
            mem_pend = 1;
            mem_cnt = lat;
            mem_addr = s_addr;
        end
        if (fl) pcIn = tgt;
        else if (s_adv) pcIn = pcIn + 32'd4;
        imemRespValid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_instrValid", {31'b0, instrValid}, 32'd0);
        chk("rst_instrOut", instrOut, 32'd0);
        chk("rst_instrPc", instrPc, 32'd0);
        chk("rst_reqValid", {31'b0, imemReqValid}, 32'd0);
        chk("rst_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        @(posedge clk);
        #1 rstN = 1'b1;

        // c1..c5: streaming from PC 0
        step(0, 0, 1, 1);
        chk("c1_addr", s_addr, 32'h0);
        chk("c1_adv", {31'b0, s_adv}, 32'd1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("c3_valid", {31'b0, s_valid}, 32'd1);
        chk("c3_instr", s_out, 32'h13);
        chk("c3_pc", s_pc, 32'h0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("stream_n", delivered.size(), 32'd3);
        if (delivered.size() >= 3) begin
            chk("stream_0", delivered[0], 32'h0);
            chk("stream_1", delivered[1], 32'h4);
            chk("stream_2", delivered[2], 32'h8);
        end

        // c6..c8: decode stalled, queue fills to DEPTH
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("full_valid", {31'b0, s_valid}, 32'd1);
        chk("full_req", {31'b0, s_req}, 32'd0);
        chk("full_adv", {31'b0, s_adv}, 32'd0);
        chk("full_head", s_pc, 32'hC);
        chk("full_pcIn", pcIn, 32'h14);
        step(0, 0, 1, 1);
        chk("resume_addr", s_addr, 32'h14);
        chk("resume_adv", {31'b0, s_adv}, 32'd1);

        // c10: request 0x18 with 2-cycle memory; c11 flush to 0x100 while it is in flight
        lat = 2;
        step(0, 0, 1, 1);
        step(1, 32'h100, 1, 1);
        step(0, 0, 1, 1);
        chk("drop_req", {31'b0, s_req}, 32'd0);
        chk("drop_valid", {31'b0, s_valid}, 32'd0);
        lat = 1;
        step(0, 0, 1, 1);
        chk("redir_addr", s_addr, 32'h100);
        step(0, 0, 1, 1);
        // c15: flush together with response for 0x104 and a pop of 0x100
        step(1, 32'h200, 1, 1);
        chk("redir_head", s_pc, 32'h100);
        chk("flush_req", {31'b0, s_req}, 32'd0);

        // c16..c18: memory not ready; c19 accept
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("stall_req", {31'b0, s_req}, 32'd1);
        chk("stall_adv", {31'b0, s_adv}, 32'd0);
        chk("stall_addr", s_addr, 32'h200);
        chk("stall_valid", {31'b0, s_valid}, 32'd0);
        lat = 3;
        step(0, 0, 1, 1);
        chk("stall_accept", {31'b0, s_adv}, 32'd1);
        step(0, 0, 1, 1);

        // Asynchronous reset while a request is outstanding
        #2 rstN = 1'b0;
        #1;
        chk("arst_instrValid", {31'b0, instrValid}, 32'd0);
        chk("arst_instrOut", instrOut, 32'd0);
        chk("arst_instrPc", instrPc, 32'd0);
        chk("arst_reqValid", {31'b0, imemReqValid}, 32'd0);
        chk("arst_pcAdvance", {31'b0, pcAdvance}, 32'd0);
        mq.delete();
        m_busy = 0;
        m_drop = 0;
        mem_pend = 0;
        lat = 1;
        pcIn = 32'h300;
        @(posedge clk);
        #1 rstN = 1'b1;
        step(0, 0, 1, 1);
        chk("post_rst_addr", s_addr, 32'h300);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
